// File: rtl/pulse_measure_pkg.sv
// Shared types and helpers for the pulse width measurement block.
// Latency: none (types, constants and a constant function only).
// Backpressure: not applicable.
package pulse_measure_pkg;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        IDLE    = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int DROP_CNT_W = 8;

    // Largest value a counter of cnt_w bits can hold.
    function automatic logic [31:0] sat_value(input int unsigned cnt_w);
        if (cnt_w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one asynchronous bit, resets to 0.
// Latency: STAGES clk cycles from d to q.
// Backpressure: none; samples every cycle.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pulse_measure.sv
// Measures high pulses on async i_x in clk cycles, rejects glitches, optional drop counter (PULSE_MEASURE_DROP_CNT_EN).
// Latency: o_valid rises SYNC_STAGES edges after the first edge sampling i_x low.
// Backpressure: one-deep output; a result arriving while a held result is stalled is discarded with an o_drop strobe.
module pulse_measure
    import pulse_measure_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MIN_WIDTH   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             i_reset_n,
    input  logic             i_x,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_width,
    output logic             o_overflow,
    output logic             o_drop
`ifdef PULSE_MEASURE_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] o_drop_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_value(CNT_W));
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_WIDTH);

    logic                   s;
    logic [SYNC_STAGES-1:0] fill;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   res_vld;
    logic                   drop_now;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (i_reset_n),
        .d     (i_x),
        .q     (s)
    );

    // The synchronizer shows its reset value until it has been refilled; track when s is trustworthy.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fill <= '0;
        end else begin
            fill <= {fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // A measurement ends on the first low of s; only widths at or above the minimum produce a result.
    always_comb begin
        res_vld  = (state == MEASURE) && !s && (cnt >= MIN_CNT);
        drop_now = res_vld && o_valid && !i_ready;
    end

    // Arm / idle / measure sequencing with a saturating width counter.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ARM;
            cnt   <= '0;
        end else begin
            case (state)
                ARM: begin
                    if (fill[SYNC_STAGES-1] && !s) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (s) begin
                        state <= MEASURE;
                        cnt   <= CNT_W'(1);
                    end
                end
                MEASURE: begin
                    if (s) begin
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= ARM;
                end
            endcase
        end
    end

    // One-entry output register with valid/ready handshake and drop strobe.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid    <= 1'b0;
            o_width    <= '0;
            o_overflow <= 1'b0;
            o_drop     <= 1'b0;
        end else begin
            o_drop <= drop_now;
            if (res_vld && (!o_valid || i_ready)) begin
                o_valid    <= 1'b1;
                o_width    <= cnt;
                o_overflow <= (cnt == CNT_MAX);
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef PULSE_MEASURE_DROP_CNT_EN
    // Saturating count of discarded results, counted on the edge that raises o_drop.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_drop_cnt <= '0;
        end else if (drop_now && (o_drop_cnt != '1)) begin
            o_drop_cnt <= o_drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_measure.sv
// Directed bench for pulse_measure: a 16-bit and a 4-bit instance share stimulus.
// A pulse-level model predicts every output cycle; literal checks pin key results.
// Inputs change at posedge+4, outputs are compared at posedge+2 and logged at posedge+8.
module tb_pulse_measure;

    localparam int SYNC = 2;
    localparam int MINW = 2;
    localparam longint MAX16 = 65535;
    localparam longint MAX4  = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_x = 1'b0;
    logic        i_ready = 1'b1;
    logic        v16, ov16, dr16, v4, ov4, dr4;
    logic [15:0] w16;
    logic [3:0]  w4;
`ifdef PULSE_MEASURE_DROP_CNT_EN
    logic [7:0]  dc16, dc4;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pulse_measure #(.CNT_W(16), .MIN_WIDTH(MINW), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .i_reset_n(rst_n), .i_x(i_x), .i_ready(i_ready),
        .o_valid(v16), .o_width(w16), .o_overflow(ov16), .o_drop(dr16)
`ifdef PULSE_MEASURE_DROP_CNT_EN
        , .o_drop_cnt(dc16)
`endif
    );

    pulse_measure #(.CNT_W(4), .MIN_WIDTH(MINW), .SYNC_STAGES(SYNC)) dut4 (
        .clk(clk), .i_reset_n(rst_n), .i_x(i_x), .i_ready(i_ready),
        .o_valid(v4), .o_width(w4), .o_overflow(ov4), .o_drop(dr4)
`ifdef PULSE_MEASURE_DROP_CNT_EN
        , .o_drop_cnt(dc4)
`endif
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- pulse-level model ----------------
    // Runs of high samples are measured only if a low sample has been seen since reset release.
    // A finished run becomes a result SYNC edges after its first low sample.
    int  edge_n = 0;
    bit  armed = 0;
    int  run_len = 0;
    bit  pv[8];
    int  pl[8];
    bit  mv = 0;
    int  mlen = 0;
    bit  mdrop = 0;
    int  mdcnt = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            edge_n = 0; armed = 0; run_len = 0;
            mv = 0; mlen = 0; mdrop = 0; mdcnt = 0;
            for (int k = 0; k < 8; k++) begin pv[k] = 0; pl[k] = 0; end
        end else begin
            bit due;
            int dlen;
            edge_n++;
            due  = pv[edge_n % 8];
            dlen = pl[edge_n % 8];
            pv[edge_n % 8] = 0;
            mdrop = 0;
            if (due) begin
                if (!mv || i_ready) begin mv = 1; mlen = dlen; end
                else begin
                    mdrop = 1;
                    if (mdcnt < 255) mdcnt++;
                end
            end else if (mv && i_ready) begin
                mv = 0;
            end
            if (i_x) begin
                if (armed) run_len++;
            end else begin
                if (run_len >= MINW) begin
                    pv[(edge_n + SYNC) % 8] = 1;
                    pl[(edge_n + SYNC) % 8] = run_len;
                end
                run_len = 0;
                armed = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(posedge clk);
        #2;
        chk("valid16", v16, mv);
        chk("valid4", v4, mv);
        chk("drop16", dr16, mdrop);
        chk("drop4", dr4, mdrop);
        if (mv) begin
            chk("width16", w16, (mlen > MAX16) ? MAX16 : mlen);
            chk("ovf16", ov16, (mlen >= MAX16) ? 1 : 0);
            chk("width4", w4, (mlen > MAX4) ? MAX4 : mlen);
            chk("ovf4", ov4, (mlen >= MAX4) ? 1 : 0);
        end
`ifdef PULSE_MEASURE_DROP_CNT_EN
        chk("drop_cnt16", dc16, mdcnt);
        chk("drop_cnt4", dc4, mdcnt);
`endif
    end

    // ---------------- transfer / drop logger ----------------
    int xq[$];
    int oq[$];
    int w4q[$];
    int o4q[$];
    int ndrop = 0;

    initial forever begin
        @(posedge clk);
        #8;
        if (rst_n && v16 && i_ready) begin
            xq.push_back(int'(w16));
            oq.push_back(int'(ov16));
        end
        if (rst_n && v4 && i_ready) begin
            w4q.push_back(int'(w4));
            o4q.push_back(int'(ov4));
        end
        if (rst_n && dr16) ndrop++;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #4;
        end
    endtask

    task automatic pulse(input int w, input int gap);
        i_x = 1'b1;
        tick(w);
        i_x = 1'b0;
        tick(gap);
    endtask

    task automatic expect_one(input string nm, input int base, input int b4,
                              input int w, input int o, input int ww4, input int oo4);
        chk({nm, "_xfers16"}, xq.size() - base, 1);
        chk({nm, "_xfers4"}, w4q.size() - b4, 1);
        if (xq.size() > base) begin
            chk({nm, "_w16"}, xq[base], w);
            chk({nm, "_o16"}, oq[base], o);
        end
        if (w4q.size() > b4) begin
            chk({nm, "_w4"}, w4q[b4], ww4);
            chk({nm, "_o4"}, o4q[b4], oo4);
        end
    endtask

    initial begin
        int b, b4, d0;
        tick(3);
        chk("rst_valid", v16, 0);
        chk("rst_width", w16, 0);
        chk("rst_ovf", ov16, 0);
        chk("rst_drop", dr16, 0);
        rst_n = 1'b1;
        tick(5);

        // 5-cycle pulse, latency and single valid cycle
        b = xq.size(); b4 = w4q.size();
        i_x = 1'b1;
        tick(5);
        i_x = 1'b0;
        tick(2);
        chk("lat_not_yet", v16, 0);
        tick(1);
        chk("lat_valid", v16, 1);
        chk("lat_width", w16, 5);
        tick(1);
        chk("one_cycle_valid", v16, 0);
        tick(4);
        expect_one("p5", b, b4, 5, 0, 5, 0);

        // glitch rejected, then 3-cycle pulse
        b = xq.size(); b4 = w4q.size(); d0 = ndrop;
        pulse(1, 3);
        pulse(3, 6);
        expect_one("glitch_p3", b, b4, 3, 0, 3, 0);
        chk("glitch_no_drop", ndrop - d0, 0);

        // backpressure: 4 held, 7 dropped
        b = xq.size(); b4 = w4q.size(); d0 = ndrop;
        i_ready = 1'b0;
        pulse(4, 4);
        pulse(7, 5);
        chk("bp_held_valid", v16, 1);
        chk("bp_held_width", w16, 4);
        chk("bp_drops", ndrop - d0, 1);
        i_ready = 1'b1;
        tick(1);
        tick(1);
        chk("bp_after_xfer", v16, 0);
        tick(2);
        expect_one("bp", b, b4, 4, 0, 4, 0);

        // 20-cycle pulse saturates the 4-bit instance
        b = xq.size(); b4 = w4q.size();
        pulse(20, 6);
        expect_one("sat", b, b4, 20, 0, 15, 1);

        // pulse already high across reset release is ignored
        rst_n = 1'b0;
        i_x = 1'b1;
        tick(2);
        b = xq.size(); b4 = w4q.size();
        rst_n = 1'b1;
        tick(6);
        i_x = 1'b0;
        tick(3);
        pulse(3, 6);
        expect_one("arm", b, b4, 3, 0, 3, 0);

        // async reset while a result is held and a pulse is in progress
        i_ready = 1'b0;
        pulse(3, 5);
        chk("rst_mid_held", v16, 1);
        b = xq.size();
        i_x = 1'b1;
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid16", v16, 0);
        chk("rst_async_valid4", v4, 0);
        i_x = 1'b0;
        tick(2);
        rst_n = 1'b1;
        i_ready = 1'b1;
        tick(12);
        chk("rst_no_stale", xq.size() - b, 0);

`ifdef PULSE_MEASURE_DROP_CNT_EN
        // 1 held result plus 300 discarded ones
        i_ready = 1'b0;
        for (int k = 0; k < 301; k++) pulse(2, 1);
        tick(5);
        chk("dcnt_sat16", dc16, 255);
        chk("dcnt_sat4", dc4, 255);
        rst_n = 1'b0;
        #1;
        chk("dcnt_clr", dc16, 0);
        tick(2);
        rst_n = 1'b1;
        i_ready = 1'b1;
        tick(4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
